compact_word_drainer: RTL
=========================

// Module: compact_word_drainer
// PURPOSE
//  Downstream of the 16-lane compaction buffer. Accepts a compacted group of
//  0..16 valid 32-bit words per cycle: word 0 is in lane 0, and the count comes
//  from the popcount of the registered valids. Queues the words in a ring buffer
//  and drains them in order, one word per cycle, over a valid/ready stream for
//  the serial output stage.
// PARAMETERS
//  WIDTH  32  bits per word
//  LANES  16  input lanes per group
//  DEPTH  32  ring entries; power of two, >= 2*LANES
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            async active-low reset
//  in_valid   in   1            group present this cycle
//  in_count   in   5            valid words in group, 0..LANES
//  in_data    in   LANES*WIDTH  lane i = in_data[i*WIDTH +: WIDTH]
//  in_ready   out  1            free entries >= LANES
//  out_valid  out  1            head word available
//  out_data   out  WIDTH        head word
//  out_ready  in   1            consumer takes head word
//  level      out  6            occupied entries, 0..DEPTH
//  overflow   out  1            sticky: group dropped
//  count_err  out  1            sticky: in_count > LANES seen
// BEHAVIOUR
//  - Reset (async assert, sync deassert by top level): wptr=rptr=0, level=0,
//    ring cleared to 0, out_valid=0, out_data=0, in_ready=1, overflow=0,
//    count_err=0. Reset mid-drain discards all queued words.
//  - Accept: in_valid & in_ready. Lanes 0..in_count-1 are written to
//    ring[(wptr+i) mod DEPTH]. wptr += in_count. Lanes >= in_count are ignored.
//  - in_count=0 while accepting is a no-op. in_count>LANES sets count_err and
//    is clamped to LANES.
//  - in_valid & !in_ready drops the whole group and sets overflow. Partial
//    acceptance is never done.
//  - Pop: out_valid & out_ready. rptr += 1 mod DEPTH.
//  - level_next = level + accepted_count - pop. Push and pop in the same cycle
//    are both applied.
//  - Pointer arithmetic is modulo DEPTH (wrap is natural). level is kept
//    separately and is never derived from the pointers.
//  - in_ready, out_valid, out_data and level are registered, so all outputs
//    come straight from flops.
//  - Latency: a word accepted on edge N is visible on out_data after edge N
//    when the queue was empty at that edge (first word out one cycle after
//    acceptance).
//  - Words drain in lane order, then in group order. Order is preserved across
//    the wrap.
//  - out_data holds its value while out_valid & !out_ready. It is 0 when empty.
//  - in_ready_next = (DEPTH - level_next) >= LANES.
// STRUCTURE
//  - Shared package: WIDTH/LANES/DEPTH defaults, PTR_W=$clog2(DEPTH),
//    LVL_W=PTR_W+1.
//  - One sub-module, multi_write_ring: DEPTH x WIDTH register array with
//    LANES write ports (base pointer + count) and one read port at rptr.
//    The top level holds pointers, level, flags and output registers.
// TESTING
//  1 Reset with rst_n=0 -> level=0, out_valid=0, out_data=0, in_ready=1, flags=0.
//  2 Push count=3 {A,B,C}, out_ready=1 -> A,B,C on 3 consecutive cycles from
//    N+1, then out_valid=0, level=0.
//  3 out_ready=0, push 16 twice -> level=32, in_ready=0. A third push is
//    dropped: overflow=1, level stays 32.
//  4 Push 12,12,12 with pops interleaved to force a wrap past entry 31 ->
//    output sequence matches input order exactly.
//  5 At level=16, push count=5 and pop in the same cycle -> level=20; the head
//    word advances by one.
//  6 Push count=0 -> no change. Push count=20 -> count_err=1 and 16 words
//    queued. Assert rst_n mid-drain -> queue empty immediately.

Source files
------------

// File: rtl/compact_word_drainer_pkg.sv
// Shared sizing constants for the compacted-group drainer and its ring buffer.
// All widths are derived from WIDTH/LANES/DEPTH so the slice stays consistent.
package compact_word_drainer_pkg;

  localparam int WIDTH = 32;
  localparam int LANES = 16;
  localparam int DEPTH = 32;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(LANES) + 1;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LVL_W-1:0] lvl_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counts above LANES are treated as a full group.
  function automatic cnt_t clamp_count(input cnt_t c);
    return (c > cnt_t'(LANES)) ? cnt_t'(LANES) : c;
  endfunction

endpackage

// File: rtl/compact_word_drainer_multi_write_ring.sv
// DEPTH x WIDTH register array: up to LANES consecutive writes per cycle starting
// at a base pointer (wrapping modulo DEPTH), plus one asynchronous read port.
module compact_word_drainer_multi_write_ring
  import compact_word_drainer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [PTR_W-1:0]       wr_base,
  input  logic [CNT_W-1:0]       wr_count,
  input  logic [LANES*WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]       rd_addr,
  output logic [WIDTH-1:0]       rd_data
);

  word_t mem [DEPTH];

  // NOTE: the array is reset because the queue must come up cleared; that
  // forces it into flops rather than an SRAM macro, which is fine at this depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (wr_en) begin
      // Lane i lands at base+i; the count caps at LANES <= DEPTH so targets never collide.
      for (int i = 0; i < LANES; i++) begin
        if (cnt_t'(i) < wr_count)
          mem[wr_base + ptr_t'(i)] <= wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/compact_word_drainer.sv
// Queues compacted groups of 0..LANES words into a ring and drains them one per
// cycle over valid/ready. Every output is driven directly from a flop.
module compact_word_drainer
  import compact_word_drainer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [CNT_W-1:0]       in_count,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [LVL_W-1:0]       level,
  output logic                   overflow,
  output logic                   count_err
);

  ptr_t  wptr, rptr;
  ptr_t  wptr_next, rptr_next;
  lvl_t  level_next;
  cnt_t  acc_count;
  word_t head_next, rd_data;
  logic  accept, pop, drop, bad_count, in_ready_next;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    accept     = in_valid & in_ready;
    drop       = in_valid & ~in_ready;
    bad_count  = in_valid & (in_count > cnt_t'(LANES));
    pop        = out_valid & out_ready;
    acc_count  = '0;
    if (accept) acc_count = clamp_count(in_count);

    level_next    = level + lvl_t'(acc_count) - lvl_t'(pop);
    wptr_next     = wptr + ptr_t'(acc_count);
    rptr_next     = rptr + ptr_t'(pop);
    in_ready_next = (level_next <= lvl_t'(DEPTH - LANES));

    // When the queue is empty after this cycle's pop, the new head is lane 0
    // of the group being written now, which the ring cannot return yet.
    head_next = '0;
    if (level_next != '0) begin
      if (level == lvl_t'(pop)) head_next = in_data[WIDTH-1:0];
      else                      head_next = rd_data;
    end
  end

  compact_word_drainer_multi_write_ring u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept),
    .wr_base  (wptr),
    .wr_count (acc_count),
    .wr_data  (in_data),
    .rd_addr  (rptr_next),
    .rd_data  (rd_data)
  );

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      count_err <= 1'b0;
    end else begin
      wptr      <= wptr_next;
      rptr      <= rptr_next;
      level     <= level_next;
      in_ready  <= in_ready_next;
      out_valid <= (level_next != '0);
      out_data  <= head_next;
      if (drop)      overflow  <= 1'b1;
      if (bad_count) count_err <= 1'b1;
    end
  end

endmodule
